pc_seq: RTL and testbench

- Parametrised program-counter sequencer; successor to the fixed 7-bit increment-only program counter.
- Drives the instruction-memory address and supports:
  - increment
  - absolute jump
  - PC-relative branch
  - call/return through an internal return-address stack
- Sits between the control StateMachine (command strobes) and instruction memory (mem_addr). Flags stack misuse to the controller.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_ret_stack.sv | 54 +++++
 rtl/pc_seq.sv | 94 +++++++++
 tb/tb_pc_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: command encoding and the
// per-cycle priority decode (Ret > Call > Ld > Br > Up > hold).
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BR,
    OP_LD,
    OP_CALL,
    OP_RET
  } pc_op_e;

  function automatic pc_op_e decode_op(input logic ret, input logic call,
                                       input logic ld, input logic br,
                                       input logic up);
    pc_op_e op;
    if (ret)       op = OP_RET;
    else if (call) op = OP_CALL;
    else if (ld)   op = OP_LD;
    else if (br)   op = OP_BR;
    else if (up)   op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack; push/pop take effect on the rising edge, dout is the top entry.
// Push while full and pop while empty are silently dropped; the parent flags the misuse.
module pc_ret_stack #(
  parameter  int AW          = 7,
  parameter  int STACK_DEPTH = 4,
  localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Clr_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] mem_q [STACK_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(STACK_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Entry contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (do_push && (cnt_q == CW'(i))) mem_q[i] <= din;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) dout = mem_q[i];
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: increment, jump, relative branch, call/return; one-cycle latency.
// Stack overflow/underflow leaves mem_addr unchanged and sets the sticky err flag.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter  int AW          = 7,
  parameter  int OW          = 5,
  parameter  int STACK_DEPTH = 4,
  parameter  int RESET_ADDR  = 0,
  localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Clr_n,
  input  logic          Up,
  input  logic          Ld,
  input  logic [AW-1:0] Ld_addr,
  input  logic          Br,
  input  logic [OW-1:0] Br_off,
  input  logic          Call,
  input  logic          Ret,
  input  logic          Err_clr,
  output logic [AW-1:0] mem_addr,
  output logic [CW-1:0] stk_cnt,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          err
);

  pc_op_e        op;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] br_ext;
  logic [AW-1:0] stk_top;
  logic          push, pop;
  logic          ovf, unf;

  assign op       = decode_op(Ret, Call, Ld, Br, Up);
  assign addr_inc = mem_addr_q + AW'(1);
  assign br_ext   = AW'($signed(Br_off));

  assign ovf  = (op == OP_CALL) && stk_full;
  assign unf  = (op == OP_RET) && stk_empty;
  assign push = (op == OP_CALL) && !stk_full;
  assign pop  = (op == OP_RET) && !stk_empty;

  pc_ret_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .push  (push),
    .pop   (pop),
    .din   (addr_inc),
    .dout  (stk_top),
    .cnt   (stk_cnt),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    mem_addr_d = mem_addr_q;
    unique case (op)
      OP_INC:  mem_addr_d = addr_inc;
      OP_BR:   mem_addr_d = mem_addr_q + br_ext;
      OP_LD:   mem_addr_d = Ld_addr;
      OP_CALL: if (!stk_full)  mem_addr_d = Ld_addr;
      OP_RET:  if (!stk_empty) mem_addr_d = stk_top;
      default: mem_addr_d = mem_addr_q;
    endcase
  end

  // A new error in the same cycle as Err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (ovf || unf)   err_d = 1'b1;
    else if (Err_clr) err_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      mem_addr_q <= AW'(RESET_ADDR);
      err_q      <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq with default parameters (AW=7, OW=5, depth 4).
module tb_pc_seq;

  logic       Clk;
  logic       Clr_n;
  logic       Up, Ld, Br, Call, Ret, Err_clr;
  logic [6:0] Ld_addr;
  logic [4:0] Br_off;
  logic [6:0] mem_addr;
  logic [2:0] stk_cnt;
  logic       stk_full, stk_empty, err;

  int total  = 0;
  int passed = 0;

  pc_seq dut (
    .Clk       (Clk),
    .Clr_n     (Clr_n),
    .Up        (Up),
    .Ld        (Ld),
    .Ld_addr   (Ld_addr),
    .Br        (Br),
    .Br_off    (Br_off),
    .Call      (Call),
    .Ret       (Ret),
    .Err_clr   (Err_clr),
    .mem_addr  (mem_addr),
    .stk_cnt   (stk_cnt),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .err       (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic idle();
    Up = 0; Ld = 0; Br = 0; Call = 0; Ret = 0; Err_clr = 0;
  endtask

  task automatic load(input logic [6:0] a);
    idle();
    Ld = 1; Ld_addr = a;
    step();
    Ld = 0;
  endtask

  initial begin
    idle();
    Ld_addr = '0; Br_off = '0;
    Clr_n = 0;
    #12;
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_cnt", 32'(stk_cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_empty", 32'(stk_empty), 1);
    chk("rst_full", 32'(stk_full), 0);
    Clr_n = 1;

    // Increment 20 times from reset
    Up = 1;
    for (int i = 0; i < 20; i++) step();
    chk("inc20", 32'(mem_addr), 20);

    // Wrap 127 -> 0
    load(7'd127);
    chk("ld127", 32'(mem_addr), 127);
    Up = 1; step();
    chk("inc_wrap", 32'(mem_addr), 0);

    // Asynchronous reset between edges
    load(7'd33);
    chk("ld33", 32'(mem_addr), 33);
    Up = 1; step();
    chk("inc34", 32'(mem_addr), 34);
    #2 Clr_n = 0;
    #1;
    chk("async_rst", 32'(mem_addr), 0);
    Up = 0;
    #1 Clr_n = 1;

    // Relative branches
    load(7'd10);
    Br = 1; Br_off = 5'b11101; step();
    chk("br_m3", 32'(mem_addr), 7);
    Br_off = 5'd15; step();
    chk("br_p15", 32'(mem_addr), 22);
    load(7'd1);
    Br = 1; Br_off = 5'b11101; step();
    chk("br_wrap", 32'(mem_addr), 126);
    Br_off = 5'd0; step();
    chk("br_zero", 32'(mem_addr), 126);
    Br = 0;

    // Ld outranks Br and Up
    load(7'd5);
    Ld = 1; Br = 1; Up = 1; Ld_addr = 7'd40; Br_off = 5'd3; step();
    chk("prio_addr", 32'(mem_addr), 40);
    chk("prio_cnt", 32'(stk_cnt), 0);

    // Nested call / return
    load(7'd3);
    Call = 1; Ld_addr = 7'd50; step();
    chk("call1_addr", 32'(mem_addr), 50);
    chk("call1_cnt", 32'(stk_cnt), 1);
    Ld_addr = 7'd90; step();
    chk("call2_addr", 32'(mem_addr), 90);
    chk("call2_cnt", 32'(stk_cnt), 2);
    Call = 0; Ret = 1; step();
    chk("ret1_addr", 32'(mem_addr), 51);
    chk("ret1_cnt", 32'(stk_cnt), 1);
    step();
    chk("ret2_addr", 32'(mem_addr), 4);
    chk("ret2_empty", 32'(stk_empty), 1);
    chk("ret2_err", 32'(err), 0);
    Ret = 0;

    // Fill the stack from 4: pushes 5, 11, 21, 31
    Call = 1;
    Ld_addr = 7'd10; step();
    Ld_addr = 7'd20; step();
    Ld_addr = 7'd30; step();
    Ld_addr = 7'd40; step();
    chk("fill_addr", 32'(mem_addr), 40);
    chk("fill_full", 32'(stk_full), 1);
    chk("fill_cnt", 32'(stk_cnt), 4);
    chk("fill_err", 32'(err), 0);
    Ld_addr = 7'd99; step();
    chk("ovf_addr", 32'(mem_addr), 40);
    chk("ovf_cnt", 32'(stk_cnt), 4);
    chk("ovf_err", 32'(err), 1);
    Call = 0; step();
    chk("err_sticky", 32'(err), 1);
    Err_clr = 1; step();
    chk("err_clr", 32'(err), 0);
    Err_clr = 0;

    // LIFO unwind
    Ret = 1;
    step(); chk("pop1", 32'(mem_addr), 31);
    step(); chk("pop2", 32'(mem_addr), 21);
    step(); chk("pop3", 32'(mem_addr), 11);
    step(); chk("pop4", 32'(mem_addr), 5);
    chk("pop_empty", 32'(stk_empty), 1);
    Ret = 0;

    idle(); step();
    chk("hold_addr", 32'(mem_addr), 5);

    // Underflow with simultaneous Call: Ret wins
    Ret = 1; Call = 1; Ld_addr = 7'd77; step();
    chk("unf_addr", 32'(mem_addr), 5);
    chk("unf_err", 32'(err), 1);
    chk("unf_cnt", 32'(stk_cnt), 0);
    Call = 0; Err_clr = 1; step();
    chk("set_wins_err", 32'(err), 1);
    chk("set_wins_addr", 32'(mem_addr), 5);
    Ret = 0; step();
    chk("final_clr", 32'(err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
